// File: rtl/cyclic_encoder_param.sv
// -----------------------------------------------------------------------------
// cyclic_encoder_param
//
// Serial systematic (N,K) cyclic encoder. K message bits arrive MSB-first and
// are passed straight through to the output with zero latency. While they pass,
// an LFSR divides m(x)*x^(N-K) by g(x). The N-K remainder bits are then shifted
// out MSB-first as parity. Both sides use valid/ready handshakes. The upstream
// side is stalled whenever the downstream side stalls.
//
// Parameters:
//   N    codeword length (N > K >= 1)
//   K    message length
//   GEN  generator polynomial, width N-K+1, MSB = x^(N-K); GEN[N-K]=GEN[0]=1
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-high reset
//   enable   global clock enable; low freezes all state and blocks transfers
//   abort    synchronous frame abort (effective only while enable=1)
//   s_valid  input bit valid
//   s_ready  encoder can accept an input bit
//   s_data   message bit, highest power first
//   m_valid  output bit valid
//   m_ready  downstream accepts the output bit
//   m_data   codeword bit
//   m_last   high on the final (N-th) codeword bit
//   busy     high while a frame is partially transferred
// -----------------------------------------------------------------------------
module cyclic_encoder_param #(
  parameter int           N   = 15,
  parameter int           K   = 11,
  parameter logic [N-K:0] GEN = 5'b10011
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic abort,
  input  logic s_valid,
  output logic s_ready,
  input  logic s_data,
  output logic m_valid,
  input  logic m_ready,
  output logic m_data,
  output logic m_last,
  output logic busy
);

  localparam int P  = N - K;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] LAST_DATA = CW'(K - 1);
  localparam logic [CW-1:0] LAST_CW   = CW'(N - 1);

  typedef enum logic {
    DATA   = 1'b0,
    PARITY = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [P-1:0]  r;
  logic          xfer;

  // One division step of the remainder register. The feedback bit is the
  // incoming message bit XORed with the current remainder MSB. The x^(N-K) term
  // of g(x) is implicit, so only GEN[N-K-1:0] is folded back in.
  function automatic logic [P-1:0] div_step(input logic [P-1:0] rem,
                                            input logic         fb);
    div_step = (rem << 1) ^ (fb ? GEN[P-1:0] : '0);
  endfunction

  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    m_data  = 1'b0;
    m_last  = 1'b0;
    xfer    = 1'b0;
    if (state == DATA) begin
      // Message bits pass straight through. Upstream readiness mirrors
      // downstream readiness, so a stall on one side holds both sides.
      s_ready = m_ready & enable;
      m_valid = s_valid & enable;
      m_data  = s_data;
      xfer    = s_valid & m_ready & enable;
    end else begin
      m_valid = enable;
      m_data  = r[P-1];
      m_last  = (cnt == LAST_CW);
      xfer    = enable & m_ready;
    end
  end

  assign busy = (cnt != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= DATA;
      cnt   <= '0;
      r     <= '0;
    end else if (enable) begin
      if (abort) begin
        // Abort wins over any transfer. The bit offered this cycle is dropped.
        state <= DATA;
        cnt   <= '0;
        r     <= '0;
      end else if (xfer) begin
        if (state == DATA) begin
          r   <= div_step(r, s_data ^ r[P-1]);
          cnt <= cnt + CW'(1);
          if (cnt == LAST_DATA) state <= PARITY;
        end else if (cnt == LAST_CW) begin
          // Return to DATA at once so the next frame can start next cycle.
          state <= DATA;
          cnt   <= '0;
          r     <= '0;
        end else begin
          r   <= r << 1;
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cyclic_encoder_param.sv
module tb_cyclic_encoder_param;

  localparam int           N   = 15;
  localparam int           K   = 11;
  localparam int           P   = N - K;
  localparam logic [P:0]   GEN = 5'b10011;

  logic clk = 1'b0;
  logic reset, enable, abort, s_valid, s_data, m_ready;
  logic s_ready, m_valid, m_data, m_last, busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cyclic_encoder_param #(.N(N), .K(K), .GEN(GEN)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .abort  (abort),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .m_last (m_last),
    .busy   (busy)
  );

  // Reference: GF(2) long division of m(x)*x^P by g(x); codeword = {m, rem}.
  function automatic logic [N-1:0] ref_cw(input logic [K-1:0] msg);
    logic [N-1:0] div;
    logic [N-1:0] g;
    g   = N'(GEN);
    div = N'(msg) << P;
    for (int b = N - 1; b >= P; b--)
      if (div[b]) div = div ^ (g << (b - P));
    return {msg, div[P-1:0]};
  endfunction

  // Runs one frame (or its first nbits transfers) cycle by cycle.
  // mode 0: always ready/enabled; mode 1: m_ready toggles, enable low 3 cycles
  // at the second parity bit; mode 2: random m_ready and enable.
  task automatic run_frame(input logic [K-1:0] msg, input int mode,
                           input int nbits, output logic [N-1:0] cw);
    logic [N-1:0] exp;
    int  i, cyc, gap;
    logic prev_stall, prev_d, exp_valid, exp_sready, xfer;
    exp = ref_cw(msg);
    cw = '0; i = 0; cyc = 0; gap = 0; prev_stall = 1'b0; prev_d = 1'b0;
    while (i < nbits) begin
      @(negedge clk);
      abort = 1'b0;
      case (mode)
        0: begin enable = 1'b1; m_ready = 1'b1; end
        1: begin
          m_ready = (cyc % 2 == 0);
          if (i == K + 1 && gap < 3) begin enable = 1'b0; gap++; end
          else enable = 1'b1;
        end
        default: begin
          enable  = ($urandom_range(0, 4) != 0);
          m_ready = ($urandom_range(0, 2) != 0);
        end
      endcase
      s_valid = (i < K);
      s_data  = (i < K) ? msg[K-1-i] : 1'($urandom_range(0, 1));
      #1;
      exp_valid  = enable && ((i < K) ? s_valid : 1'b1);
      exp_sready = (i < K) ? (m_ready && enable) : 1'b0;
      xfer       = exp_valid && m_ready;
      n_checks++;
      if (m_valid !== exp_valid) begin
        n_errors++;
        $display("FAIL m_valid bit%0d cyc%0d got %b exp %b", i, cyc, m_valid, exp_valid);
      end
      n_checks++;
      if (s_ready !== exp_sready) begin
        n_errors++;
        $display("FAIL s_ready bit%0d cyc%0d got %b exp %b", i, cyc, s_ready, exp_sready);
      end
      n_checks++;
      if (busy !== (i != 0)) begin
        n_errors++;
        $display("FAIL busy bit%0d cyc%0d got %b exp %b", i, cyc, busy, (i != 0));
      end
      n_checks++;
      if (m_last !== (i == N - 1)) begin
        n_errors++;
        $display("FAIL m_last bit%0d cyc%0d got %b exp %b", i, cyc, m_last, (i == N - 1));
      end
      if (exp_valid) begin
        n_checks++;
        if (m_data !== exp[N-1-i]) begin
          n_errors++;
          $display("FAIL m_data bit%0d cyc%0d got %b exp %b", i, cyc, m_data, exp[N-1-i]);
        end
        if (prev_stall) begin
          n_checks++;
          if (m_data !== prev_d) begin
            n_errors++;
            $display("FAIL stall_hold bit%0d got %b exp %b", i, m_data, prev_d);
          end
        end
      end
      if (xfer) begin
        cw[N-1-i] = m_data;
        i++;
      end
      prev_stall = exp_valid && !m_ready;
      prev_d     = m_data;
      cyc++;
      if (cyc > 500) begin
        n_errors++;
        $display("FAIL frame_timeout got %0d bits exp %0d", i, nbits);
        break;
      end
    end
  endtask

  task automatic check_cw(input string name, input logic [N-1:0] got,
                          input logic [N-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %b exp %b", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; abort = 1'b0;
    s_valid = 1'b0; s_data = 1'b1; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++;
    if (s_ready !== 1'b1) begin n_errors++; $display("FAIL reset_sready got %b exp 1", s_ready); end
    n_checks++;
    if (m_valid !== 1'b0) begin n_errors++; $display("FAIL reset_mvalid got %b exp 0", m_valid); end
    n_checks++;
    if (m_last !== 1'b0) begin n_errors++; $display("FAIL reset_mlast got %b exp 0", m_last); end
    n_checks++;
    if (m_data !== 1'b1) begin n_errors++; $display("FAIL reset_mdata got %b exp 1", m_data); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_zero();
    logic [N-1:0] cw;
    run_frame(11'b00000000000, 0, N, cw);
    check_cw("zero_msg", cw, 15'b000000000000000);
    @(negedge clk); s_valid = 1'b0; #1;
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL zero_busy_after got %b exp 0", busy); end
  endtask

  task automatic test_single();
    logic [N-1:0] cw;
    run_frame(11'b00000000001, 0, N, cw);
    check_cw("single_one", cw, 15'b000000000010011);
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] cw;
    run_frame(11'b10000000000, 0, N, cw);
    check_cw("b2b_first", cw, 15'b100000000001001);
    run_frame(11'b11111111111, 0, N, cw);
    check_cw("b2b_ones", cw, 15'b111111111111111);
  endtask

  task automatic test_stall_enable();
    logic [N-1:0] cw;
    run_frame(11'b00000000001, 1, N, cw);
    check_cw("stall_enable", cw, 15'b000000000010011);
  endtask

  task automatic test_abort();
    logic [N-1:0] cw;
    run_frame(11'b10000000000, 0, 6, cw);
    @(negedge clk);
    enable = 1'b1; m_ready = 1'b1; abort = 1'b1; s_valid = 1'b1; s_data = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b1) begin n_errors++; $display("FAIL abort_busy_before got %b exp 1", busy); end
    @(negedge clk);
    abort = 1'b0; s_valid = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy_after got %b exp 0", busy); end
    run_frame(11'b00000000001, 0, N, cw);
    check_cw("after_abort", cw, 15'b000000000010011);
  endtask

  task automatic test_reset_mid_frame();
    logic [N-1:0] cw;
    run_frame(11'b10000000000, 0, K + 1, cw);
    @(negedge clk);
    enable = 1'b1; m_ready = 1'b1; s_valid = 1'b1; s_data = 1'b1;
    #1;
    n_checks++;
    if (s_ready !== 1'b0) begin n_errors++; $display("FAIL midrst_parity_sready got %b exp 0", s_ready); end
    reset = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
    n_checks++;
    if (s_ready !== 1'b1) begin n_errors++; $display("FAIL midrst_sready got %b exp 1", s_ready); end
    n_checks++;
    if (m_data !== 1'b1) begin n_errors++; $display("FAIL midrst_passthru got %b exp 1", m_data); end
    s_data = 1'b0;
    #1;
    n_checks++;
    if (m_data !== 1'b0) begin n_errors++; $display("FAIL midrst_passthru0 got %b exp 0", m_data); end
    @(negedge clk);
    reset = 1'b0; s_valid = 1'b0;
    run_frame(11'b00000000001, 0, N, cw);
    check_cw("after_midrst", cw, 15'b000000000010011);
  endtask

  task automatic test_random();
    logic [N-1:0] cw;
    logic [K-1:0] msg;
    for (int f = 0; f < 20; f++) begin
      msg = K'($urandom);
      run_frame(msg, 2, N, cw);
      check_cw("random_frame", cw, ref_cw(msg));
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_single();
    test_back_to_back();
    test_stall_enable();
    test_abort();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
